// File: rtl/dbus_pkg.sv
// Data-bus request/response types shared by the core's Memory stage and its responders.
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder.sv
// Word-organised, byte-strobed data RAM that terminates the dbus with a fixed access latency.
// Handshake: valid is sampled only in IDLE; addr_ok pulses the cycle after, data_ok LATENCY cycles later.
module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [31:0] mem [MEM_WORDS];

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
  logic [3:0]       lat_strobe_q, lat_strobe_d;
  logic [31:0]      lat_wdata_q, lat_wdata_d;
  logic             addr_ok_q, addr_ok_d;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      data_q, data_d;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_req_bits;

  assign req_idx = dreq.addr[IDX_W+1:2];
  assign unused_req_bits = ^{dreq.size, dreq.addr[31:IDX_W+2], dreq.addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_idx_d    = lat_idx_q;
    lat_strobe_d = lat_strobe_q;
    lat_wdata_d  = lat_wdata_q;
    addr_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    data_d       = 32'h0;
    rd_idx       = lat_idx_q;

    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          lat_idx_d    = req_idx;
          lat_strobe_d = dreq.strobe;
          lat_wdata_d  = dreq.data;
          addr_ok_d    = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
            rd_idx  = req_idx;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data is captured on entry to RESP, before the write lands on exit.
    if (state_d == RESP) begin
      data_ok_d = 1'b1;
      data_d    = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      lat_idx_q    <= '0;
      lat_strobe_q <= 4'd0;
      lat_wdata_q  <= 32'h0;
      addr_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      data_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_idx_q    <= lat_idx_d;
      lat_strobe_q <= lat_strobe_d;
      lat_wdata_q  <= lat_wdata_d;
      addr_ok_q    <= addr_ok_d;
      data_ok_q    <= data_ok_d;
      data_q       <= data_d;
    end
  end

  // A reset arriving in RESP cancels the pending write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_strobe_q[i]) mem[lat_idx_q][8*i +: 8] <= lat_wdata_q[8*i +: 8];
      end
    end
  end

  assign dresp.addr_ok = addr_ok_q;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = data_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 2, 0, 4) against a transaction-level model.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  req  [3];
  dbus_resp_t resp [3];

  int lat_tab [3] = '{2, 0, 4};

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit cmp_en = 0;

  // model state per instance
  bit [31:0] mm [3][1024];
  int        ao_cyc [3];
  int        do_cyc [3];
  bit [31:0] do_data [3];
  bit        wpend [3];
  bit [9:0]  widx [3];
  bit [3:0]  wstrb [3];
  bit [31:0] wdat [3];
  int        nfree [3];

  dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .dreq(req[0]), .dresp(resp[0]));
  dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .dreq(req[1]), .dresp(resp[1]));
  dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .dreq(req[2]), .dresp(resp[2]));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: one transaction at a time, timed purely by cycle arithmetic
  initial begin
    for (int k = 0; k < 3; k++) begin
      ao_cyc[k] = -1; do_cyc[k] = -1; wpend[k] = 0; nfree[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          ao_cyc[k] = -1; do_cyc[k] = -1; wpend[k] = 0; nfree[k] = cyc + 1;
        end else begin
          if (wpend[k] && cyc == do_cyc[k]) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[k][b]) mm[k][widx[k]][8*b +: 8] = wdat[k][8*b +: 8];
            wpend[k] = 0;
          end
          if (req[k].valid && cyc >= nfree[k]) begin
            widx[k]    = req[k].addr[11:2];
            wstrb[k]   = req[k].strobe;
            wdat[k]    = req[k].data;
            wpend[k]   = (req[k].strobe != 4'b0);
            ao_cyc[k]  = cyc + 1;
            do_cyc[k]  = cyc + 1 + lat_tab[k];
            do_data[k] = mm[k][widx[k]];
            nfree[k]   = cyc + 2 + lat_tab[k];
          end
        end
      end
      cyc++;
    end
  end

  // scoreboard compare: every cycle, every instance
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("L%0d addr_ok", lat_tab[k]), {31'b0, resp[k].addr_ok}, {31'b0, cyc == ao_cyc[k]});
          chk($sformatf("L%0d data_ok", lat_tab[k]), {31'b0, resp[k].data_ok}, {31'b0, cyc == do_cyc[k]});
          chk($sformatf("L%0d data", lat_tab[k]), resp[k].data, (cyc == do_cyc[k]) ? do_data[k] : 32'h0);
        end
      end
    end
  end

  // driver: one transaction; request fields are scrambled after acceptance
  task automatic txn(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                     input bit drop, output logic [31:0] rd, output int aol, output int dol);
    int t0;
    bit done;
    @(negedge clk);
    req[k] = '{valid: 1'b1, addr: a, size: 3'd2, strobe: s, data: wd};
    t0 = cyc; aol = -1; dol = -1; rd = 32'h0; done = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (resp[k].addr_ok) aol = cyc - t0;
      if (resp[k].data_ok) begin
        rd = resp[k].data; dol = cyc - t0; done = 1;
      end
      if (n == 1) begin
        req[k].addr   = $urandom;
        req[k].data   = $urandom;
        req[k].strobe = 4'($urandom_range(0, 15));
        if (drop) req[k].valid = 1'b0;
      end
    end
    req[k].valid = 1'b0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL L%0d timeout: no data_ok within 40 cycles", lat_tab[k]);
    end
  endtask

  logic [31:0] rd;
  int aol, dol;
  int t0, nao, ndo, ncoin, nbad;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) req[k] = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("reset data", resp[k].data, 32'h0);
      chk("reset ok flags", {30'b0, resp[k].addr_ok, resp[k].data_ok}, 32'h0);
    end
    reset = 1'b0;

    // read latency at LATENCY=2
    txn(0, 32'h10, 4'hf, 32'hDEADBEEF, 0, rd, aol, dol);
    txn(0, 32'h10, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("L2 read data", rd, 32'hDEADBEEF);
    chk("L2 addr_ok lat", aol, 1);
    chk("L2 data_ok lat", dol, 3);

    // byte and half writes
    txn(0, 32'h0, 4'hf, 32'h11223344, 0, rd, aol, dol);
    txn(0, 32'h0, 4'b0100, 32'h00AA0000, 0, rd, aol, dol);
    txn(0, 32'h0, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("sb merge", rd, 32'h11AA3344);
    txn(0, 32'h0, 4'b0011, 32'h0000BEEF, 0, rd, aol, dol);
    txn(0, 32'h2, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("sh merge", rd, 32'h11AABEEF);

    // read-before-write and address wrap
    txn(0, 32'h4, 4'hf, 32'h01020304, 0, rd, aol, dol);
    txn(0, 32'h0000_1004, 4'hf, 32'hCAFEF00D, 0, rd, aol, dol);
    chk("rbw old word", rd, 32'h01020304);
    txn(0, 32'h4, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("wrap read", rd, 32'hCAFEF00D);

    // LATENCY=0 single and back-to-back
    txn(1, 32'h0, 4'hf, 32'hA5A55A5A, 0, rd, aol, dol);
    txn(1, 32'h0, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("L0 read data", rd, 32'hA5A55A5A);
    chk("L0 addr_ok lat", aol, 1);
    chk("L0 data_ok lat", dol, 1);
    @(negedge clk);
    req[1] = '{valid: 1'b1, addr: 32'h0, size: 3'd2, strobe: 4'h0, data: 32'h0};
    t0 = cyc; nao = 0; ndo = 0; ncoin = 0; nbad = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 6) req[1].valid = 1'b0;
      if (resp[1].addr_ok) nao++;
      if (resp[1].data_ok) ndo++;
      if (resp[1].addr_ok && resp[1].data_ok) ncoin++;
      if (resp[1].data_ok && (i % 2 == 0)) nbad++;
    end
    chk("b2b completions", ndo, 3);
    chk("b2b addr_ok count", nao, 3);
    chk("b2b coincident", ncoin, 3);
    chk("b2b off-beat pulses", nbad, 0);

    // reset mid-operation at LATENCY=4
    txn(2, 32'h8, 4'hf, 32'h0BADF00D, 0, rd, aol, dol);
    chk("L4 data_ok lat", dol, 5);
    @(negedge clk);
    req[2] = '{valid: 1'b1, addr: 32'h8, size: 3'd2, strobe: 4'hf, data: 32'h12345678};
    t0 = cyc;
    @(negedge clk);
    chk("L4 accept addr_ok", {31'b0, resp[2].addr_ok}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req[2].valid = 1'b0;
    chk("post-reset data", resp[2].data, 32'h0);
    chk("post-reset flags", {30'b0, resp[2].addr_ok, resp[2].data_ok}, 32'h0);
    ndo = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp[2].data_ok) ndo++;
    end
    chk("aborted data_ok", ndo, 0);
    txn(2, 32'h8, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("aborted write", rd, 32'h0BADF00D);

    // early valid drop still completes the write
    txn(0, 32'h20, 4'hf, 32'h77665544, 1, rd, aol, dol);
    chk("drop data_ok lat", dol, 3);
    txn(0, 32'h20, 4'h0, 32'h0, 0, rd, aol, dol);
    chk("drop write lands", rd, 32'h77665544);
    txn(2, 32'h24, 4'b1001, 32'hAB0000CD, 1, rd, aol, dol);
    chk("L4 drop data_ok lat", dol, 5);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Data-bus responder that services the `dbus_req_t` requests issued by the CPU Memory stage and answers with `dbus_resp_t`. It models on-chip data RAM for simulation and FPGA bring-up. The RAM is word-organised, byte-strobed, and has a configurable fixed access latency. It sits between the core's dbus port and nothing else: it is the terminating end of the data-bus protocol.

## Interface
Parameters:
- `MEM_WORDS`, 1024: RAM depth in 32-bit words. Must be a power of two. `IDX_W = $clog2(MEM_WORDS)`.
- `LATENCY`, 2: extra cycles between address acceptance and data return. Legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `dreq`  in  `dbus_req_t`  request: `valid`, `addr[31:0]`, `size`, `strobe[3:0]`, `data[31:0]`.
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data[31:0]`.

## Operation
- States are IDLE, WAIT and RESP, held in a 2-bit register. There is also a 4-bit down-counter `cnt` and latched request registers `lat_idx`, `lat_strobe`, `lat_wdata`.
- IDLE: if `dreq.valid` is 1 at the edge:
  - latch `lat_idx = dreq.addr[IDX_W+1:2]`, `lat_strobe`, `lat_wdata`.
  - if `LATENCY == 0`, go to RESP; otherwise go to WAIT with `cnt = LATENCY-1`.
- WAIT: decrement `cnt` each cycle. When `cnt == 0`, go to RESP.
- RESP: lasts exactly one cycle, then unconditionally returns to IDLE. It never re-samples `dreq` in this cycle.
- Addressing:
  - `addr[1:0]` is ignored for indexing.
  - Address bits above `IDX_W+1` are ignored, so accesses wrap modulo `MEM_WORDS*4` bytes.
  - `size` is ignored; `strobe` is authoritative.
- Write (`lat_strobe != 0`):
  - at the edge leaving RESP, for each i with `lat_strobe[i] = 1`, set `mem[lat_idx][8i+7:8i] = lat_wdata[8i+7:8i]`.
  - `dresp.data` in RESP is the old word (read-before-write).
- Read (`lat_strobe == 0`): `dresp.data` in RESP is `mem[lat_idx]`, the full word. Byte/half extraction and sign-extension belong to the writeback stage.
- Only one transaction is outstanding at a time. No pipelining of back-to-back requests.
- A request whose `valid` drops after acceptance still completes, including the write, and still raises `data_ok`.
- Changes to `dreq` fields after acceptance are ignored; the latched copy is used.
- RAM contents are not initialised by reset. The bench preloads them via `$readmemh` or hierarchical write.

## Timing
- Reset (synchronous):
  - state goes to IDLE, `cnt = 0`.
  - `dresp.addr_ok = 0`, `dresp.data_ok = 0`, `dresp.data = 0`.
  - RAM is unchanged.
  - Reset asserted in WAIT or RESP aborts the transaction. A pending write is not performed, and no `data_ok` follows.
- All `dresp` fields are registered. There is no combinational path from `dreq` to `dresp`.
- `valid` is sampled in cycle T (IDLE), after which:
  - `addr_ok = 1` for exactly cycle T+1.
  - `data_ok = 1` for exactly cycle T+1+LATENCY.
  - With `LATENCY = 0`, both are high in cycle T+1.
- `dresp.data` is valid only while `data_ok = 1`. It is 0 in all other cycles.
- Throughput: the next request can be sampled at the earliest in cycle T+2+LATENCY. The initiator holds `valid` through the `data_ok` cycle and may present a new request the following cycle.
- `valid` held high continuously with a constant request produces one transaction every `LATENCY+2` cycles.

## Test plan
- Read latency: preload `mem[4] = 32'hDEADBEEF`, `LATENCY = 2`, then read `addr = 32'h10` at T -> `addr_ok` at T+1 only, `data_ok` at T+3 only, `data = 32'hDEADBEEF`, and `data` is 0 at T+2 and T+4.
- Byte/half writes:
  - `mem[0] = 32'h11223344`; SB-style write with strobe `4'b0100`, data `32'h00AA0000` -> later read returns `32'h11AA3344`.
  - Then strobe `4'b0011`, data `32'h0000BEEF` -> read returns `32'h11AABEEF`.
- Read-before-write and wrap:
  - `MEM_WORDS = 1024`: write `32'hCAFEF00D`, strobe `4'b1111`, to `addr = 32'h0000_1004` -> the `data_ok` cycle returns the prior `mem[1]`.
  - Read `addr = 32'h4` -> `32'hCAFEF00D`.
- `LATENCY = 0` back-to-back: with `valid` held high for 6 cycles on reads of `0x0` -> `addr_ok` and `data_ok` are coincident, pulsing every 2nd cycle, 3 completions in total.
- Reset mid-operation: `LATENCY = 4`, assert `reset` 2 cycles after accepting a write of `32'h12345678` to `0x8` -> no `data_ok` appears, all outputs are 0 the cycle after reset, and `mem[2]` is unchanged.
- Early valid drop: deassert `valid` the cycle after acceptance -> `data_ok` still appears at T+1+LATENCY and the write lands.
